// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-channel registered multiplexer with valid/ready handshakes.
// An internal arbiter (round-robin or fixed lowest-index priority) chooses
// one valid producer. Its word goes into a one-entry output register that
// honours backpressure. The register can drain and reload on the same edge,
// so it sustains one word per cycle.
module mux_rr_nx1 #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Flat input bus split into per-channel words
    logic [WIDTH-1:0] ch_data_s [N_CH];

    // Arbitration results
    logic [N_CH-1:0]  grant_s;
    logic [SEL_W-1:0] gidx_s;
    logic             found_s;
    logic [SEL_W:0]   idx_s;      // one spare bit so rr_ptr + offset cannot overflow
    logic [SEL_W-1:0] ptr_next_s;
    logic             load_en_s;
    logic             xfer_s;

    // State
    logic [SEL_W-1:0] rr_ptr_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_sel_r;
    logic             out_valid_r;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign ch_data_s[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The register can take a new word when it is empty or is being drained now
    assign load_en_s = ~out_valid_r | out_ready;
    assign xfer_s    = found_s & load_en_s;
    assign in_ready  = grant_s & {N_CH{load_en_s}};

    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
    assign out_valid = out_valid_r;

    // Arbiter: scan the channels and pick the first valid one.
    // Fixed mode scans from 0. Round-robin mode scans from rr_ptr and wraps
    // explicitly at N_CH, so non-power-of-two channel counts never alias.
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (mode) begin
                idx_s = (SEL_W+1)'(k);
            end else begin
                idx_s = {1'b0, rr_ptr_r} + (SEL_W+1)'(k);
                if (idx_s >= (SEL_W+1)'(N_CH)) begin
                    idx_s = idx_s - (SEL_W+1)'(N_CH);
                end else begin
                    idx_s = idx_s;
                end
            end
            if (!found_s && in_valid[idx_s[SEL_W-1:0]]) begin
                found_s = 1'b1;
                gidx_s  = idx_s[SEL_W-1:0];
            end else begin
                found_s = found_s;
                gidx_s  = gidx_s;
            end
        end
        if (found_s) begin
            grant_s[gidx_s] = 1'b1;
        end else begin
            grant_s = grant_s;
        end
    end

    // Pointer advance: the channel after the winner, wrapping at N_CH-1
    always_comb begin
        ptr_next_s = '0;
        if (gidx_s == SEL_W'(N_CH - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = gidx_s + SEL_W'(1);
        end
    end

    // Output register and round-robin pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= '0;
            out_data_r  <= '0;
            out_sel_r   <= '0;
            out_valid_r <= 1'b0;
        end else if (xfer_s) begin
            out_data_r  <= ch_data_s[gidx_s];
            out_sel_r   <= gidx_s;
            out_valid_r <= 1'b1;
            if (!mode) begin
                rr_ptr_r <= ptr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Testbench for mux_rr_nx1. It drives a 4-channel instance against a
// behavioural arbiter model, and a 3-channel instance for the wrap case.
module tb_mux_rr_nx1;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // 4-channel DUT signals
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic        mode, out_ready, out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;

    // 3-channel DUT signals
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic        mode3, out_ready3, out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_sel3;

    mux_rr_nx1 #(.N_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_rr_nx1 #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .out_data(out_data3), .out_sel(out_sel3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state for the 4-channel instance
    bit         m_valid;
    logic [7:0] m_data;
    int         m_sel;
    int         m_ptr;

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    // Winner by rule: the first valid channel in search order, or -1 if none
    function automatic int pick(input logic [3:0] v, input logic md, input int ptr);
        for (int k = 0; k < 4; k++) begin
            int c = md ? k : (ptr + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One clock: sample in_ready mid-cycle with its prediction, then advance the model at the edge
    task automatic cycle(output logic [3:0] exp_rdy, output logic [3:0] act_rdy);
        int g;
        bit load;
        @(negedge clk);
        load    = !m_valid || out_ready;
        g       = pick(in_valid, mode, m_ptr);
        exp_rdy = (load && g >= 0) ? (4'b0001 << g) : 4'b0000;
        act_rdy = in_ready;
        @(posedge clk);
        if (load && g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_sel   = g;
            if (!mode) m_ptr = (g + 1) % 4;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", out_sel); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_rr_fair();
        logic [3:0] er, ar;
        mode = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 6; i++) begin
            cycle(er, ar);
            checks++; if (ar !== er) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, ar, er); end
            checks++; if (out_sel !== 2'(i % 4)) begin errors++; $display("FAIL rr_sel[%0d]: got %0d want %0d", i, out_sel, i % 4); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (out_data !== 8'h10 + 8'(i % 4)) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, out_data, 8'h10 + 8'(i % 4)); end
        end
    endtask

    task automatic test_fixed();
        logic [3:0] er, ar;
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(er, ar);
            checks++; if (ar !== 4'b0001) begin errors++; $display("FAIL fixed_ready[%0d]: got %b want 0001", i, ar); end
            checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL fixed_sel[%0d]: got %0d want 0", i, out_sel); end
            checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL fixed_data[%0d]: got %h want 10", i, out_data); end
        end
        // Pointer was left at 2 by the round-robin run and must survive fixed mode
        mode = 1'b0;
        cycle(er, ar);
        checks++; if (ar !== er) begin errors++; $display("FAIL fixed_to_rr_ready: got %b want %b", ar, er); end
        checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL fixed_to_rr_sel: got %0d want 2", out_sel); end
    endtask

    task automatic test_single();
        logic [3:0] er, ar;
        mode = 1'b0; out_ready = 1'b1; in_valid = 4'b0100;
        in_data = $urandom;
        in_data[23:16] = 8'hA5;
        cycle(er, ar);
        checks++; if (ar !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", ar); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", out_data); end
        checks++; if (out_sel !== 2'd2) begin errors++; $display("FAIL single_sel: got %0d want 2", out_sel); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        in_valid = 4'b0000;
        cycle(er, ar);
        checks++; if (ar !== 4'b0000) begin errors++; $display("FAIL single_idle_ready: got %b want 0000", ar); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_drain_data: got %h want a5", out_data); end
    endtask

    task automatic test_backpressure();
        logic [3:0] er, ar;
        logic [7:0] hold_d;
        logic [1:0] hold_s;
        mode = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
        in_data = {8'h43, 8'h42, 8'h41, 8'h40};
        cycle(er, ar);
        hold_d = 8'h40 + 8'(m_sel);
        hold_s = 2'(m_sel);
        checks++; if (out_data !== hold_d) begin errors++; $display("FAIL bp_load_data: got %h want %h", out_data, hold_d); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(er, ar);
            checks++; if (ar !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, ar); end
            checks++; if (out_data !== hold_d || out_sel !== hold_s) begin errors++; $display("FAIL bp_hold[%0d]: got %h/%0d want %h/%0d", i, out_data, out_sel, hold_d, hold_s); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
        end
        out_ready = 1'b1;
        cycle(er, ar);
        checks++; if (ar !== (4'b0001 << ((hold_s + 1) % 4))) begin errors++; $display("FAIL bp_release_ready: got %b want %b", ar, 4'b0001 << ((hold_s + 1) % 4)); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b want 1", out_valid); end
        checks++; if (out_sel !== 2'((hold_s + 1) % 4)) begin errors++; $display("FAIL bp_release_sel: got %0d want %0d", out_sel, (hold_s + 1) % 4); end
    endtask

    task automatic test_random();
        logic [3:0] er, ar;
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            cycle(er, ar);
            checks++; if (ar !== er) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, ar, er); end
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, m_valid); end
            checks++; if (out_data !== m_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, out_data, m_data); end
            checks++; if (out_sel !== 2'(m_sel)) begin errors++; $display("FAIL rand_sel[%0d]: got %0d want %0d", i, out_sel, m_sel); end
        end
    endtask

    task automatic test_wrap3();
        in_valid3 = 3'b101; mode3 = 1'b0; out_ready3 = 1'b1;
        in_data3 = {8'h32, 8'h31, 8'h30};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (in_ready3 !== ((i % 2) ? 3'b100 : 3'b001)) begin errors++; $display("FAIL wrap3_ready[%0d]: got %b want %b", i, in_ready3, (i % 2) ? 3'b100 : 3'b001); end
            checks++; if (dut3.rr_ptr_r == 2'd3) begin errors++; $display("FAIL wrap3_ptr[%0d]: got 3 want 0..2", i); end
            @(posedge clk); #1;
            checks++; if (out_sel3 !== ((i % 2) ? 2'd2 : 2'd0)) begin errors++; $display("FAIL wrap3_sel[%0d]: got %0d want %0d", i, out_sel3, (i % 2) ? 2 : 0); end
            checks++; if (out_data3 !== ((i % 2) ? 8'h32 : 8'h30) || out_valid3 !== 1'b1) begin errors++; $display("FAIL wrap3_data[%0d]: got %h/%b", i, out_data3, out_valid3); end
        end
        in_valid3 = 3'b000;
    endtask

    task automatic test_reset_mid();
        logic [3:0] er, ar;
        in_valid = 4'b0000; out_ready = 1'b1; mode = 1'b0;
        cycle(er, ar);
        in_valid = 4'b0010; out_ready = 1'b0;
        in_data = {8'h63, 8'h62, 8'h61, 8'h60};
        cycle(er, ar);
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1) begin errors++; $display("FAIL rstmid_setup: got %b/%0d want 1/1", out_valid, out_sel); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00 || out_sel !== 2'd0) begin errors++; $display("FAIL rstmid_outs: got %h/%0d want 00/0", out_data, out_sel); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 4'hF; out_ready = 1'b1;
        cycle(er, ar);
        checks++; if (ar !== 4'b0001) begin errors++; $display("FAIL rstmid_ready: got %b want 0001", ar); end
        checks++; if (out_sel !== 2'd0 || out_data !== 8'h60) begin errors++; $display("FAIL rstmid_first: got %0d/%h want 0/60", out_sel, out_data); end
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = 32'h0; in_valid = 4'h0; mode = 1'b0; out_ready = 1'b0;
        in_data3 = 24'h0; in_valid3 = 3'h0; mode3 = 1'b0; out_ready3 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_rr_fair();
        test_fixed();
        test_single();
        test_backpressure();
        test_random();
        test_wrap3();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
